// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - CPU-side byte-stream bridge to an AXI4-lite UART Lite slave
//
// Purpose:
//   Buffers core TX bytes and UART RX bytes in two small FIFOs and autonomously
//   polls the UART Lite STAT register, moving at most one byte per poll so the
//   core never waits on the bus.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   tx_valid/tx_ready/tx_data  core -> TX FIFO byte stream
//   rx_valid/rx_ready/rx_data  RX FIFO -> core byte stream (first-word fall-through)
//   axi_err                  one-cycle pulse on any non-OKAY rresp/bresp
//   axi_aw*/w*/b*/ar*/r*     AXI4-lite master, 32-bit address/data
module uart_io_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int          RX_DEPTH      = 16,
  parameter int          TX_DEPTH      = 16,
  parameter int          POLL_INTERVAL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        axi_err,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arprot,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW-1:0] TX_PTR_ONE = 1;
  localparam logic [RX_AW-1:0] RX_PTR_ONE = 1;
  localparam logic [TX_AW:0]   TX_CNT_ONE = 1;
  localparam logic [RX_AW:0]   RX_CNT_ONE = 1;
  localparam logic [TX_AW:0]   TX_FULL    = TX_DEPTH[TX_AW:0];
  localparam logic [RX_AW:0]   RX_FULL    = RX_DEPTH[RX_AW:0];
  localparam logic [31:0]      POLL_LIM   = POLL_INTERVAL;
  localparam logic [31:0]      ADDR_RX    = BASE_ADDR;
  localparam logic [31:0]      ADDR_TX    = BASE_ADDR + 32'd4;
  localparam logic [31:0]      ADDR_STAT  = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_STAT, ST_RD_RX, ST_WR_TX} state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [TX_AW:0]   r_tx_cnt;
  logic             w_tx_push, w_tx_pop;
  logic [7:0]       w_tx_head;

  // ---------------- RX FIFO ----------------
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [RX_AW:0]   r_rx_cnt;
  logic             w_rx_push, w_rx_pop;

  // ---------------- FSM / bus registers ----------------
  state_t      r_state;
  logic [31:0] r_poll_cnt;
  logic [31:0] r_araddr, r_wdata;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_err;

  logic w_r_hs, w_b_hs, w_take_rx, w_take_tx;
  logic w_unused_rdata;

  assign tx_ready  = (r_tx_cnt != TX_FULL);
  assign w_tx_push = tx_valid & tx_ready;
  assign w_tx_head = r_tx_mem[r_tx_rptr];

  assign rx_valid  = (r_rx_cnt != '0);
  assign rx_data   = r_rx_mem[r_rx_rptr];
  assign w_rx_pop  = rx_valid & rx_ready;

  assign w_r_hs    = axi_rvalid & r_rready;
  assign w_b_hs    = axi_bvalid & r_bready;

  // STAT decision, evaluated on the STAT read-data handshake; RX has priority.
  assign w_take_rx = axi_rdata[0] & (r_rx_cnt != RX_FULL);
  assign w_take_tx = ~axi_rdata[3] & (r_tx_cnt != '0);
  assign w_tx_pop  = (r_state == ST_STAT) & w_r_hs & ~w_take_rx & w_take_tx;
  assign w_rx_push = (r_state == ST_RD_RX) & w_r_hs;

  assign w_unused_rdata = &axi_rdata[31:8];

  assign axi_awaddr  = ADDR_TX;
  assign axi_awprot  = 3'b000;
  assign axi_arprot  = 3'b000;
  assign axi_wstrb   = 4'b0001;
  assign axi_awvalid = r_awvalid;
  assign axi_wvalid  = r_wvalid;
  assign axi_wdata   = r_wdata;
  assign axi_bready  = r_bready;
  assign axi_araddr  = r_araddr;
  assign axi_arvalid = r_arvalid;
  assign axi_rready  = r_rready;
  assign axi_err     = r_err;

  // FIFO storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= axi_rdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TX_CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - TX_CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RX_CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_poll_cnt <= '0;
      r_araddr   <= ADDR_STAT;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      // Errors are only reported; the sequence continues as if OKAY.
      r_err <= (w_r_hs & (axi_rresp != 2'b00)) | (w_b_hs & (axi_bresp != 2'b00));
      case (r_state)
        ST_IDLE: begin
          if (r_poll_cnt == POLL_LIM) begin
            r_araddr  <= ADDR_STAT;
            r_arvalid <= 1'b1;
            r_rready  <= 1'b1;
            r_state   <= ST_STAT;
          end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
          end
        end
        ST_STAT: begin
          if (r_arvalid & axi_arready) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_rready <= 1'b0;
            if (w_take_rx) begin
              r_araddr  <= ADDR_RX;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
              r_state   <= ST_RD_RX;
            end else if (w_take_tx) begin
              r_wdata   <= {24'b0, w_tx_head};
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_TX;
            end else begin
              r_poll_cnt <= '0;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_RD_RX: begin
          if (r_arvalid & axi_arready) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_rready   <= 1'b0;
            r_poll_cnt <= POLL_LIM;   // a byte moved: poll again at once
            r_state    <= ST_IDLE;
          end
        end
        ST_WR_TX: begin
          if (r_awvalid & axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid & axi_wready)   r_wvalid  <= 1'b0;
          if (r_bready) begin
            if (axi_bvalid) begin
              r_bready   <= 1'b0;
              r_poll_cnt <= POLL_LIM;
              r_state    <= ST_IDLE;
            end
          end else if ((~r_awvalid | axi_awready) & (~r_wvalid | axi_wready)) begin
            // AW and W are both accepted (either earlier or in this cycle).
            r_bready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb/tb_uart_io_ctrl.sv - directed self-checking bench for uart_io_ctrl
module tb_uart_io_ctrl;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [7:0]  EV_S = 8'h53, EV_R = 8'h52, EV_W = 8'h57;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tx_valid, tx_ready, rx_valid, rx_ready, axi_err;
  logic [7:0]  tx_data, rx_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, bvalid, bready, arvalid, rvalid, rready;
  logic [1:0]  bresp, rresp;
  wire         wready  = 1'b1;
  wire         arready = 1'b1;

  uart_io_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .axi_err(axi_err),
    .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready)
  );

  // Second instance with a poll interval, served by an always-empty UART.
  logic        p_tx_ready, p_rx_valid, p_err, p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
  logic        p_rvalid;
  logic [7:0]  p_rx_data;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [2:0]  p_awprot, p_arprot;
  logic [3:0]  p_wstrb;

  uart_io_ctrl #(.POLL_INTERVAL(3)) dut_p3 (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(1'b0), .tx_ready(p_tx_ready), .tx_data(8'h00),
    .rx_valid(p_rx_valid), .rx_ready(1'b0), .rx_data(p_rx_data),
    .axi_err(p_err),
    .axi_awaddr(p_awaddr), .axi_awprot(p_awprot), .axi_awvalid(p_awvalid), .axi_awready(1'b1),
    .axi_wdata(p_wdata), .axi_wstrb(p_wstrb), .axi_wvalid(p_wvalid), .axi_wready(1'b1),
    .axi_bresp(2'b00), .axi_bvalid(1'b0), .axi_bready(p_bready),
    .axi_araddr(p_araddr), .axi_arprot(p_arprot), .axi_arvalid(p_arvalid), .axi_arready(1'b1),
    .axi_rdata(32'h0), .axi_rresp(2'b00), .axi_rvalid(p_rvalid), .axi_rready(p_rready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model controls (written only by the stimulus block)
  logic       s_tx_full, s_bit2;
  logic [7:0] s_rxbyte;
  logic [1:0] s_bresp;
  int         s_rx_req;

  // Slave model state and logs (written only by the slave process)
  int          rx_served = 0, n_ar_rx = 0, n_ar_stat = 0, n_wstrb_bad = 0, n_err = 0;
  int          last_stat_cyc = 0, prev_stat_cyc = 0, rx_r_cyc = 0;
  logic [31:0] last_rx_addr = '0;
  logic        rd_is_rx = 1'b0, got_aw = 1'b0, got_w = 1'b0;
  logic [7:0]  ev[$];
  logic [31:0] wq_data[$], wq_addr[$];

  always @(posedge clk) begin
    if (axi_err) n_err <= n_err + 1;
    if (!rst_n) begin
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      bvalid <= 1'b0; bresp <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
    end else begin
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        if (rd_is_rx) begin
          rx_served <= rx_served + 1;
          rx_r_cyc  <= cyc;
        end
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        if (araddr == BASE + 32'd8) begin
          rdata <= {28'b0, s_tx_full, s_bit2, 1'b0, (rx_served != s_rx_req)};
          rd_is_rx <= 1'b0;
          n_ar_stat <= n_ar_stat + 1;
          prev_stat_cyc <= last_stat_cyc;
          last_stat_cyc <= cyc;
          ev.push_back(EV_S);
        end else begin
          rdata <= {24'b0, s_rxbyte};
          rd_is_rx <= 1'b1;
          n_ar_rx <= n_ar_rx + 1;
          last_rx_addr <= araddr;
          ev.push_back(EV_R);
        end
      end
      if (awvalid && awready) begin
        got_aw <= 1'b1;
        wq_addr.push_back(awaddr);
      end
      if (wvalid && wready) begin
        got_w <= 1'b1;
        wq_data.push_back(wdata);
        if (wstrb !== 4'b0001) n_wstrb_bad <= n_wstrb_bad + 1;
        ev.push_back(EV_W);
      end
      if (got_aw && got_w && !bvalid) begin
        bvalid <= 1'b1; bresp <= s_bresp; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  int p_last = 0, p_prev = 0, p_aw_seen = 0;
  always @(posedge clk) begin
    if (!rst_n) p_rvalid <= 1'b0;
    else begin
      if (p_rvalid && p_rready) p_rvalid <= 1'b0;
      if (p_arvalid) begin
        p_rvalid <= 1'b1; p_prev <= p_last; p_last <= cyc;
      end
      if (p_awvalid || p_wvalid) p_aw_seen <= p_aw_seen + 1;
    end
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int ev_base, w1, w2, s_between, rx_base, wbase, npop;

  initial begin
    rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h77; rx_ready = 1'b0; awready = 1'b1;
    s_tx_full = 1'b0; s_bit2 = 1'b0; s_rxbyte = 8'h00; s_bresp = 2'b00; s_rx_req = 0;

    // 1: reset state, first poll right after reset release
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_araddr", araddr, BASE + 32'd8);
    chk("rst_wdata", wdata, 0);
    chk("rst_err", axi_err, 0);
    chk("tie_prot_strb", {awprot, arprot, wstrb}, 32'h1);
    chk("tie_awaddr", awaddr, BASE + 32'd4);
    rst_n = 1'b1; tx_valid = 1'b0;
    @(negedge clk);
    chk("first_arvalid", arvalid, 1);
    chk("first_araddr", araddr, BASE + 32'd8);

    // 2: idle polling cadence with STAT = 0
    repeat (30) @(negedge clk);
    chk("gap_p0", last_stat_cyc - prev_stat_cyc, 3);
    chk("gap_p3", p_last - p_prev, 6);
    chk("p3_polled", (p_last > p_prev) && (p_prev > 0), 1);
    chk("no_writes", wq_data.size(), 0);
    chk("p3_no_aw", p_aw_seen, 0);

    // 3: two TX bytes, STAT = 0x4
    s_bit2 = 1'b1;
    ev_base = ev.size();
    tx_valid = 1'b1; tx_data = 8'h41;
    @(negedge clk);
    chk("tx_latency", awvalid, 0);
    tx_data = 8'h42;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 100 && wq_data.size() < 2; i++) @(negedge clk);
    chk("w_count", wq_data.size(), 2);
    chk("w0_data", wq_data.size() > 0 ? wq_data[0] : 32'hdead, 32'h41);
    chk("w1_data", wq_data.size() > 1 ? wq_data[1] : 32'hdead, 32'h42);
    chk("w0_addr", wq_addr.size() > 0 ? wq_addr[0] : 32'hdead, BASE + 32'd4);
    chk("w1_addr", wq_addr.size() > 1 ? wq_addr[1] : 32'hdead, BASE + 32'd4);
    chk("wstrb", n_wstrb_bad, 0);
    w1 = -1; w2 = -1; s_between = 0;
    for (int i = ev_base; i < ev.size(); i++) begin
      if (ev[i] == EV_W) begin
        if (w1 < 0) w1 = i;
        else if (w2 < 0) w2 = i;
      end else if (w1 >= 0 && w2 < 0 && ev[i] == EV_S) s_between++;
    end
    chk("stat_between_writes", s_between, 1);
    repeat (5) @(negedge clk);
    s_bit2 = 1'b0;

    // 4: one RX byte 0x5A
    rx_base = n_ar_rx;
    s_rxbyte = 8'h5A; s_rx_req = 1;
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    chk("rx_valid_rise", rx_valid, 1);
    chk("rx_latency", cyc - rx_r_cyc, 1);
    chk("rx_data", rx_data, 32'h5A);
    chk("rx_addr", last_rx_addr, BASE);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_pop", rx_valid, 0);
    repeat (10) @(negedge clk);
    chk("rx_reads_once", n_ar_rx - rx_base, 1);

    // 5: STAT = 0x9 with pending TX byte; then fill the RX FIFO
    s_tx_full = 1'b1;
    wbase = wq_data.size();
    tx_valid = 1'b1; tx_data = 8'h99;
    @(negedge clk);
    tx_valid = 1'b0;
    rx_base = n_ar_rx;
    s_rxbyte = 8'h11; s_rx_req = 2;
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    chk("rx_prio_data", rx_data, 32'h11);
    chk("rx_prio_nowrite", wq_data.size() - wbase, 0);
    s_rx_req = 18;
    repeat (150) @(negedge clk);
    chk("rx_full_reads", n_ar_rx - rx_base, 16);
    chk("tx_held", wq_data.size() - wbase, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("rx_refill_read", n_ar_rx - rx_base, 17);
    rx_ready = 1'b1; npop = 0;
    for (int i = 0; i < 40 && rx_valid; i++) begin
      @(negedge clk);
      npop++;
    end
    rx_ready = 1'b0;
    chk("rx_drain_count", npop, 16);
    chk("rx_drained", rx_valid, 0);

    // 6: awready stalled past wready, SLVERR on B
    awready = 1'b0; s_bresp = 2'b10;
    s_tx_full = 1'b0;
    for (int i = 0; i < 100 && !wvalid; i++) @(negedge clk);
    chk("w6_start", {awvalid, wvalid}, 2'b11);
    @(negedge clk);
    chk("w6_wvalid_drop", wvalid, 0);
    chk("w6_aw_held", awvalid, 1);
    chk("w6_no_bready", bready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w6_aw_stall", {awvalid, bready}, 2'b10);
    end
    awready = 1'b1;
    @(negedge clk);
    chk("w6_aw_done", awvalid, 0);
    chk("w6_bready", bready, 1);
    chk("w6_err_early", axi_err, 0);
    for (int i = 0; i < 20 && !axi_err; i++) @(negedge clk);
    chk("w6_err_pulse", axi_err, 1);
    chk("w6_bready_drop", bready, 0);
    @(negedge clk);
    chk("w6_err_one_cycle", axi_err, 0);
    chk("w6_err_count", n_err, 1);
    chk("w6_wdata", wq_data.size() > wbase ? wq_data[wbase] : 32'hdead, 32'h99);
    s_bresp = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
